// File: rtl/stw_time_counter_pkg.sv
// Shared constants and helpers for the stopwatch time counter.
package stw_pkg;

    localparam int unsigned DIG_W            = 4;
    localparam int unsigned DISP_W           = 8;
    localparam int unsigned DIG_MAX10        = 9;
    localparam int unsigned DIG_MAX6         = 5;
    localparam int unsigned TICK_DIV_DEFAULT = 10000;
    localparam int unsigned PRESC_W_DEFAULT  = 16;

    // Value a digit takes on the next edge given its increment and carry-out.
    function automatic logic [DIG_W-1:0] bcd_next(input logic [DIG_W-1:0] q,
                                                  input logic             inc,
                                                  input logic             carry);
        logic [DIG_W-1:0] r;
        r = q;
        if (inc) begin
            r = carry ? DIG_W'(0) : q + DIG_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/stw_time_counter_if.sv
// Control inputs and display/status outputs of the stopwatch time counter.
interface stw_time_counter_if;
    import stw_pkg::*;

    logic              stw_on;
    logic              stw_rst_n;
    logic              lap_hold;
    logic [DISP_W-1:0] cs_bcd;
    logic [DISP_W-1:0] sec_bcd;
    logic [DISP_W-1:0] min_bcd;
    logic              tick;
    logic              ovf;

    modport master (
        output stw_on, stw_rst_n, lap_hold,
        input  cs_bcd, sec_bcd, min_bcd, tick, ovf
    );

    modport slave (
        input  stw_on, stw_rst_n, lap_hold,
        output cs_bcd, sec_bcd, min_bcd, tick, ovf
    );

endinterface

// File: rtl/stw_time_counter_bcd_digit.sv
// One BCD digit counting 0..MAX with a combinational carry-out on terminal count.
module bcd_digit
    import stw_pkg::*;
#(
    parameter int unsigned MAX = DIG_MAX10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [DIG_W-1:0] q,
    output logic             carry
);

    logic [DIG_W-1:0] r_q;
    logic             w_term;

    assign w_term = (r_q == DIG_W'(MAX));
    assign carry  = inc & w_term;
    assign q      = r_q;

    // Digit register: reset and clear win over increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= w_term ? DIG_W'(0) : r_q + DIG_W'(1);
        end
    end

endmodule

// File: rtl/stw_time_counter.sv
// Stopwatch timebase: centisecond prescaler, MM:SS.CC BCD cascade, lap-hold display.
module stw_time_counter
    import stw_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned PRESC_W  = PRESC_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    stw_time_counter_if.slave  bus
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [DISP_W-1:0]  r_cs_bcd;
    logic [DISP_W-1:0]  r_sec_bcd;
    logic [DISP_W-1:0]  r_min_bcd;
    logic               r_tick;
    logic               r_ovf;

    logic               w_clr;
    logic               w_inc;
    logic               w_wrap;
    logic [DIG_W-1:0]   w_q_cs0, w_q_cs1, w_q_sec0, w_q_sec1, w_q_min0, w_q_min1;
    logic               w_c_cs0, w_c_cs1, w_c_sec0, w_c_sec1, w_c_min0, w_c_min1;
    logic [DISP_W-1:0]  w_cs_nxt;
    logic [DISP_W-1:0]  w_sec_nxt;
    logic [DISP_W-1:0]  w_min_nxt;

    assign w_clr  = ~bus.stw_rst_n;
    assign w_inc  = bus.stw_on & (r_presc == PRESC_LAST);
    assign w_wrap = w_c_min1;

    // Prescaler advances only while enabled so partial ticks survive a pause.
    always_ff @(posedge clock) begin
        if (reset || w_clr) begin
            r_presc <= '0;
        end else if (bus.stw_on) begin
            r_presc <= (r_presc == PRESC_LAST) ? PRESC_W'(0) : r_presc + PRESC_W'(1);
        end
    end

    bcd_digit #(.MAX(DIG_MAX10)) u_cs0 (
        .clock(clock), .reset(reset), .clr(w_clr), .inc(w_inc),
        .q(w_q_cs0), .carry(w_c_cs0)
    );
    bcd_digit #(.MAX(DIG_MAX10)) u_cs1 (
        .clock(clock), .reset(reset), .clr(w_clr), .inc(w_c_cs0),
        .q(w_q_cs1), .carry(w_c_cs1)
    );
    bcd_digit #(.MAX(DIG_MAX10)) u_sec0 (
        .clock(clock), .reset(reset), .clr(w_clr), .inc(w_c_cs1),
        .q(w_q_sec0), .carry(w_c_sec0)
    );
    bcd_digit #(.MAX(DIG_MAX6)) u_sec1 (
        .clock(clock), .reset(reset), .clr(w_clr), .inc(w_c_sec0),
        .q(w_q_sec1), .carry(w_c_sec1)
    );
    bcd_digit #(.MAX(DIG_MAX10)) u_min0 (
        .clock(clock), .reset(reset), .clr(w_clr), .inc(w_c_sec1),
        .q(w_q_min0), .carry(w_c_min0)
    );
    bcd_digit #(.MAX(DIG_MAX6)) u_min1 (
        .clock(clock), .reset(reset), .clr(w_clr), .inc(w_c_min0),
        .q(w_q_min1), .carry(w_c_min1)
    );

    // Post-edge live count, so the display and tick line up in the same cycle.
    always_comb begin
        w_cs_nxt  = {bcd_next(w_q_cs1,  w_c_cs0,  w_c_cs1),  bcd_next(w_q_cs0,  w_inc,    w_c_cs0)};
        w_sec_nxt = {bcd_next(w_q_sec1, w_c_sec0, w_c_sec1), bcd_next(w_q_sec0, w_c_cs1,  w_c_sec0)};
        w_min_nxt = {bcd_next(w_q_min1, w_c_min0, w_c_min1), bcd_next(w_q_min0, w_c_sec1, w_c_min0)};
    end

    // Display, tick and sticky overflow; lap-hold freezes only the display.
    always_ff @(posedge clock) begin
        if (reset || w_clr) begin
            r_cs_bcd  <= '0;
            r_sec_bcd <= '0;
            r_min_bcd <= '0;
            r_tick    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_tick <= w_inc;
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end
            if (!bus.lap_hold) begin
                r_cs_bcd  <= w_cs_nxt;
                r_sec_bcd <= w_sec_nxt;
                r_min_bcd <= w_min_nxt;
            end
        end
    end

    assign bus.cs_bcd  = r_cs_bcd;
    assign bus.sec_bcd = r_sec_bcd;
    assign bus.min_bcd = r_min_bcd;
    assign bus.tick    = r_tick;
    assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_stw_time_counter.sv
// Self-checking bench for stw_time_counter against an elapsed-centisecond model.
module tb_stw_time_counter;

    localparam int unsigned TD    = 4;
    localparam int          TOTAL = 360000;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    stw_time_counter_if bus ();

    stw_time_counter #(.TICK_DIV(TD), .PRESC_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed time as a plain centisecond count.
    int m_presc = 0;
    int m_total = 0;
    int m_disp  = 0;
    bit m_ovf   = 1'b0;
    bit m_tick  = 1'b0;

    function automatic logic [7:0] bcd2(input int v);
        logic [7:0] r;
        r = {4'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    function automatic logic [23:0] exp_time(input int t);
        logic [23:0] r;
        r = {bcd2((t / 6000) % 60), bcd2((t / 100) % 60), bcd2(t % 100)};
        return r;
    endfunction

    function automatic logic [23:0] got_time();
        logic [23:0] r;
        r = {bus.min_bcd, bus.sec_bcd, bus.cs_bcd};
        return r;
    endfunction

    // Apply one cycle of inputs, advance the model, then sample after the edge.
    task automatic cycle(input bit on, input bit rstn, input bit lap, input bit rst);
        bus.stw_on    = on;
        bus.stw_rst_n = rstn;
        bus.lap_hold  = lap;
        reset         = rst;
        @(posedge clock);
        if (rst || !rstn) begin
            m_presc = 0;
            m_total = 0;
            m_disp  = 0;
            m_ovf   = 1'b0;
            m_tick  = 1'b0;
        end else begin
            m_tick = on && (m_presc == int'(TD) - 1);
            if (on) m_presc = (m_presc + 1) % int'(TD);
            if (m_tick) begin
                m_total = m_total + 1;
                if (m_total == TOTAL) begin
                    m_total = 0;
                    m_ovf   = 1'b1;
                end
            end
            if (!lap) m_disp = m_total;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 1, 0, 1);
        cycle(0, 1, 0, 1);
        checks++;
        if (got_time() !== 24'h000000) begin
            errors++;
            $display("FAIL reset_time got %h expected 000000", got_time());
        end
        checks++;
        if (bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got %b expected 0", bus.tick);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b expected 0", bus.ovf);
        end
    endtask

    task automatic test_run40();
        int nt;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 0, 0);
            if (bus.tick === 1'b1) nt++;
            checks++;
            if (bus.tick !== m_tick) begin
                errors++;
                $display("FAIL run40_tick cyc %0d got %b expected %b", i, bus.tick, m_tick);
            end
        end
        checks++;
        if (bus.cs_bcd !== 8'h10) begin
            errors++;
            $display("FAIL run40_cs got %h expected 10", bus.cs_bcd);
        end
        checks++;
        if (nt != 10) begin
            errors++;
            $display("FAIL run40_tick_count got %0d expected 10", nt);
        end
    endtask

    task automatic test_carry();
        for (int n = 0; n < 2000 && m_total != 99; n++) begin
            cycle(1, 1, 0, 0);
            checks++;
            if (got_time() !== exp_time(m_disp)) begin
                errors++;
                $display("FAIL carry_run got %h expected %h", got_time(), exp_time(m_disp));
            end
        end
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        checks++;
        if (bus.cs_bcd !== 8'h00 || bus.sec_bcd !== 8'h01) begin
            errors++;
            $display("FAIL carry_sec got %h.%h expected 01.00", bus.sec_bcd, bus.cs_bcd);
        end
        for (int n = 0; n < 30000 && m_total != 5999; n++) begin
            cycle(1, 1, 0, 0);
            checks++;
            if (got_time() !== exp_time(m_disp)) begin
                errors++;
                $display("FAIL carry_min_run got %h expected %h", got_time(), exp_time(m_disp));
            end
        end
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        checks++;
        if (bus.min_bcd !== 8'h01 || bus.sec_bcd !== 8'h00) begin
            errors++;
            $display("FAIL carry_min got %h:%h expected 01:00", bus.min_bcd, bus.sec_bcd);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 0, 0);
        force dut.u_min1.r_q = 4'd5;
        force dut.u_min0.r_q = 4'd9;
        force dut.u_sec1.r_q = 4'd5;
        force dut.u_sec0.r_q = 4'd9;
        force dut.u_cs1.r_q  = 4'd9;
        force dut.u_cs0.r_q  = 4'd9;
        cycle(0, 1, 0, 0);
        release dut.u_min1.r_q;
        release dut.u_min0.r_q;
        release dut.u_sec1.r_q;
        release dut.u_sec0.r_q;
        release dut.u_cs1.r_q;
        release dut.u_cs0.r_q;
        m_total = TOTAL - 1;
        m_disp  = m_total;
        checks++;
        if (got_time() !== 24'h595999) begin
            errors++;
            $display("FAIL wrap_preload got %h expected 595999", got_time());
        end
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        checks++;
        if (got_time() !== 24'h000000 || bus.ovf !== 1'b1 || bus.tick !== 1'b1) begin
            errors++;
            $display("FAIL wrap got %h ovf %b tick %b expected 000000 ovf 1 tick 1",
                     got_time(), bus.ovf, bus.tick);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, 0);
            checks++;
            if (bus.ovf !== m_ovf || got_time() !== exp_time(m_disp)) begin
                errors++;
                $display("FAIL wrap_sticky got %h ovf %b expected %h ovf %b",
                         got_time(), bus.ovf, exp_time(m_disp), m_ovf);
            end
        end
        checks++;
        if (bus.ovf !== 1'b1 || bus.cs_bcd !== 8'h05) begin
            errors++;
            $display("FAIL wrap_after got cs %h ovf %b expected cs 05 ovf 1", bus.cs_bcd, bus.ovf);
        end
    endtask

    task automatic test_clear();
        for (int n = 0; n < 2000 && m_total != 123; n++) cycle(1, 1, 0, 0);
        checks++;
        if (got_time() !== 24'h000123) begin
            errors++;
            $display("FAIL clear_pre got %h expected 000123", got_time());
        end
        cycle(1, 0, 1, 0);
        checks++;
        if (got_time() !== 24'h000000 || bus.ovf !== 1'b0 || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL clear_rstn got %h ovf %b tick %b expected all 0",
                     got_time(), bus.ovf, bus.tick);
        end
        for (int i = 0; i < 37; i++) cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        checks++;
        if (got_time() !== 24'h000000 || bus.ovf !== 1'b0 || bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL clear_reset got %h ovf %b tick %b expected all 0",
                     got_time(), bus.ovf, bus.tick);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0);
            checks++;
            if (bus.tick !== m_tick) begin
                errors++;
                $display("FAIL clear_presc cyc %0d tick got %b expected %b", i, bus.tick, m_tick);
            end
        end
    endtask

    task automatic test_pause();
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 50; i++) begin
            cycle(0, 1, 0, 0);
            checks++;
            if (got_time() !== 24'h000000 || bus.tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold got %h tick %b expected 000000 tick 0",
                         got_time(), bus.tick);
            end
        end
        cycle(1, 1, 0, 0);
        checks++;
        if (bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL pause_resume1 tick got %b expected 0", bus.tick);
        end
        cycle(1, 1, 0, 0);
        checks++;
        if (bus.tick !== 1'b1 || bus.cs_bcd !== 8'h01) begin
            errors++;
            $display("FAIL pause_resume2 tick %b cs %h expected tick 1 cs 01", bus.tick, bus.cs_bcd);
        end
    endtask

    task automatic test_lap();
        cycle(0, 0, 0, 0);
        for (int n = 0; n < 100 && m_total != 5; n++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 80; i++) begin
            cycle(1, 1, 1, 0);
            checks++;
            if (got_time() !== 24'h000005) begin
                errors++;
                $display("FAIL lap_hold cyc %0d got %h expected 000005", i, got_time());
            end
        end
        cycle(1, 1, 0, 0);
        checks++;
        if (got_time() !== 24'h000025) begin
            errors++;
            $display("FAIL lap_release got %h expected 000025", got_time());
        end
    endtask

    task automatic test_random();
        bit lap;
        lap = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) lap = ~lap;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0, lap,
                  $urandom_range(0, 299) == 0);
            checks++;
            if (got_time() !== exp_time(m_disp) || bus.tick !== m_tick || bus.ovf !== m_ovf) begin
                errors++;
                $display("FAIL random cyc %0d got %h tick %b ovf %b expected %h tick %b ovf %b",
                         i, got_time(), bus.tick, bus.ovf, exp_time(m_disp), m_tick, m_ovf);
            end
        end
    endtask

    initial begin
        bus.stw_on    = 1'b0;
        bus.stw_rst_n = 1'b1;
        bus.lap_hold  = 1'b0;
        reset         = 1'b1;
        test_reset();
        test_run40();
        test_carry();
        test_wrap();
        test_clear();
        test_pause();
        test_lap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
